// File: rtl/seg7_pkg.sv
// Shared seven-segment types and the active-low hex glyph table.
// Segment vectors are ordered {g,f,e,d,c,b,a}; a 0 bit lights the segment.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    // All segments dark (common-anode, active-low drive).
    localparam seg7_t SEG_BLANK = 7'h7F;

    // Active-low glyphs for nibble values 0..F, indexed by value.
    localparam seg7_t SEG_HEX [16] = '{
        7'h40,  // 0: abcdef
        7'h79,  // 1: bc
        7'h24,  // 2: abdeg
        7'h30,  // 3: abcdg
        7'h19,  // 4: bcfg
        7'h12,  // 5: acdfg
        7'h02,  // 6: acdefg
        7'h78,  // 7: abc
        7'h00,  // 8: abcdefg
        7'h10,  // 9: abcdfg
        7'h08,  // A: abcefg
        7'h03,  // b: cdefg
        7'h46,  // C: adef
        7'h21,  // d: bcdeg
        7'h06,  // E: adefg
        7'h0E   // F: aefg
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Purely combinational nibble-to-glyph lookup.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    output seg7_t      seg
);

    // Straight table lookup; every 4-bit value has a defined glyph.
    always_comb begin
        seg = SEG_HEX[value];
    end

endmodule

// File: rtl/my_mc14495.sv
// Registered hex-to-seven-segment decoder with blanking and decimal point.
// Outputs are active-low and change only on the rising clock edge.
module my_mc14495
    import seg7_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic D0,
    input  logic D1,
    input  logic D2,
    input  logic D3,
    input  logic LE,
    input  logic point,
    output logic p,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic e,
    output logic f,
    output logic g
);

    logic [3:0] value;
    seg7_t      glyph;
    seg7_t      seg_d;
    seg7_t      seg_q;
    logic       p_d;
    logic       p_q;

    assign value = {D3, D2, D1, D0};

    hex_to_seg7 u_hex_to_seg7 (
        .value (value),
        .seg   (glyph)
    );

    // Blanking masks only a..g; the decimal point is an inverted pass-through.
    always_comb begin
        seg_d = glyph;
        p_d   = ~point;
        if (LE) begin
            seg_d = SEG_BLANK;
        end
    end

    // Output register; reset dominates every input and leaves the digit dark.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q <= SEG_BLANK;
            p_q   <= 1'b1;
        end else begin
            seg_q <= seg_d;
            p_q   <= p_d;
        end
    end

    assign {g, f, e, d, c, b, a} = seg_q;
    assign p = p_q;

endmodule

// File: tb/tb_my_mc14495.sv
// Scoreboard bench: the driver pushes expected outputs computed from the
// lit-segment letter table; the monitor pops one entry per clock and compares.
module tb_my_mc14495;

    logic clk;
    logic rst_n;
    logic D0, D1, D2, D3;
    logic LE;
    logic point;
    logic p, a, b, c, d, e, f, g;

    typedef struct {
        logic [7:0] exp;   // {p,g,f,e,d,c,b,a}
        string      tag;
    } item_t;

    item_t q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    bit    drv_done = 0;

    // Letters of the lit segments for each value, as a person would read them.
    string LIT [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                        "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                        "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    my_mc14495 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .D0    (D0),
        .D1    (D1),
        .D2    (D2),
        .D3    (D3),
        .LE    (LE),
        .point (point),
        .p     (p),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .e     (e),
        .f     (f),
        .g     (g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low {g..a} drive derived from the letters: lit letters become 0.
    function automatic logic [6:0] glyph_of(input int v);
        logic [6:0] lit;
        string s;
        lit = 7'b0;
        s = LIT[v];
        for (int i = 0; i < s.len(); i++) begin
            lit[s[i] - 8'd97] = 1'b1;
        end
        return ~lit;
    endfunction

    function automatic logic [7:0] model(input bit rst, input int v,
                                         input bit le, input bit pt);
        if (rst) return 8'hFF;
        return {~pt, (le ? 7'h7F : glyph_of(v))};
    endfunction

    // Apply one cycle of inputs, record the expected output, wait to next negedge.
    task automatic step(input bit rst, input int v, input bit le,
                        input bit pt, input string tag);
        item_t it;
        rst_n = ~rst;
        {D3, D2, D1, D0} = v[3:0];
        LE = le;
        point = pt;
        it.exp = model(rst, v, le, pt);
        it.tag = tag;
        q.push_back(it);
        @(negedge clk);
    endtask

    // Monitor: one comparison per clock, sampled just after the active edge.
    initial begin
        item_t it;
        logic [7:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                it = q.pop_front();
                act = {p, g, f, e, d, c, b, a};
                n_cmp++;
                if (act !== it.exp) begin
                    n_fail++;
                    $display("FAIL %s: got pgfedcba=%b want %b", it.tag, act, it.exp);
                end else begin
                    $display("ok   %s: pgfedcba=%b", it.tag, act);
                end
            end
        end
    end

    // Driver: directed phases from the test plan, then a randomized stretch.
    initial begin
        int v;
        rst_n = 1'b0;
        {D3, D2, D1, D0} = 4'd0;
        LE = 1'b0;
        point = 1'b0;

        step(1, 5, 0, 1, "reset0");
        step(1, 5, 0, 1, "reset1");
        step(0, 5, 0, 1, "release_v5");

        for (int i = 0; i < 16; i++) begin
            step(0, i, 0, $urandom_range(1, 0), $sformatf("sweep_v%0d", i));
        end

        for (int i = 0; i < 16; i++) begin
            step(0, i, 1, i % 2, $sformatf("blank_v%0d", i));
        end

        step(0, 10, 0, 0, "le_release_vA");

        for (int i = 0; i < 16; i++) begin
            step((i == 7 || i == 8), i, 0, 1, $sformatf("midrst_v%0d", i));
        end

        for (int i = 0; i < 200; i++) begin
            v = $urandom_range(15, 0);
            step(($urandom_range(15, 0) == 0), v, ($urandom_range(3, 0) == 0),
                 $urandom_range(1, 0), $sformatf("rand%0d_v%0d", i, v));
        end

        drv_done = 1;
        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard time bound so the run can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish by 100000");
        $fatal(1, "timeout");
    end

endmodule
